// File: rtl/mem_responder.sv
// Byte-addressed big-endian RAM responder for the CPU bus: one word access per clock,
// read data returned after READ_LATENCY edges with valid and address-fault flags.
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        wr,
  input  logic [31:0] wd,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        addr_fault
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]           mem_q [DEPTH];
  logic [ADDR_BITS-1:0] idx0_s, idx1_s, idx2_s, idx3_s;
  logic                 fault_s;
  logic [31:0]          rword_s;

  logic                 vld_q [READ_LATENCY];
  logic                 flt_q [READ_LATENCY];
  logic [31:0]          dat_q [READ_LATENCY];
  logic                 vld_d;
  logic                 flt_d;
  logic [31:0]          dat_d;

  // Byte indices wrap modulo the RAM size; the word is assembled big-endian.
  always_comb begin
    idx0_s  = address[ADDR_BITS-1:0];
    idx1_s  = idx0_s + ADDR_BITS'(1);
    idx2_s  = idx0_s + ADDR_BITS'(2);
    idx3_s  = idx0_s + ADDR_BITS'(3);
    fault_s = ((address >> ADDR_BITS) != 32'd0);
    rword_s = {mem_q[idx0_s], mem_q[idx1_s], mem_q[idx2_s], mem_q[idx3_s]};
  end

  // Stage-1 next state: writes carry only their fault bit and leave the data slot untouched.
  always_comb begin
    vld_d = ~wr;
    flt_d = fault_s;
    if (wr) begin
      dat_d = dat_q[0];
    end else begin
      dat_d = rword_s;
    end
  end

  // RAM array: not reset, and never written while reset is asserted or the address faults.
  always_ff @(posedge clk) begin
    if (reset && wr && !fault_s) begin
      mem_q[idx0_s] <= wd[31:24];
      mem_q[idx1_s] <= wd[23:16];
      mem_q[idx2_s] <= wd[15:8];
      mem_q[idx3_s] <= wd[7:0];
    end
  end

  // Read pipeline; data only advances behind a valid read so rd_data holds across write slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        flt_q[i] <= 1'b0;
        dat_q[i] <= 32'd0;
      end
    end else begin
      vld_q[0] <= vld_d;
      flt_q[0] <= flt_d;
      dat_q[0] <= dat_d;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        flt_q[i] <= flt_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign rd_data    = dat_q[READ_LATENCY-1];
  assign rd_valid   = vld_q[READ_LATENCY-1];
  assign addr_fault = flt_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a latency-1 instance driven from a vector table and a
// latency-3 instance exercised with hand-written pipelining and mid-flight reset sequences.
module tb_mem_responder;

  logic        clk;
  logic        rst1_n;
  logic        rst3_n;
  logic [31:0] address;
  logic        wr;
  logic [31:0] wd;
  logic [31:0] rd_data1, rd_data3;
  logic        rd_valid1, rd_valid3;
  logic        addr_fault1, addr_fault3;

  int total;
  int bad;

  mem_responder #(.ADDR_BITS(8), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1_n), .address(address), .wr(wr), .wd(wd),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .addr_fault(addr_fault1)
  );

  mem_responder #(.ADDR_BITS(8), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst3_n), .address(address), .wr(wr), .wd(wd),
    .rd_data(rd_data3), .rd_valid(rd_valid3), .addr_fault(addr_fault3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ev;
    logic        ef;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one request, let one rising edge take it, then sample just after the edge.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
    wr      = w;
    address = a;
    wd      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string name, input logic v, input logic f, input logic [31:0] d);
    check({name, ".valid"}, {31'd0, rd_valid3}, {31'd0, v});
    check({name, ".fault"}, {31'd0, addr_fault3}, {31'd0, f});
    check({name, ".data"}, rd_data3, d);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst1_n  = 1'b0;
    rst3_n  = 1'b0;
    wr      = 1'b0;
    address = 32'd0;
    wd      = 32'd0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0014, 32'h5566_7788, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0011, 32'h0000_0000, 1'b1, 1'b0, 32'hADBE_EF55};
    vecs[4]  = '{1'b0, 32'h0000_0012, 32'h0000_0000, 1'b1, 1'b0, 32'hBEEF_5566};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'hAABB_CCDD, 1'b0, 1'b0, 32'hBEEF_5566};
    vecs[6]  = '{1'b1, 32'h0000_00FE, 32'h1122_3344, 1'b0, 1'b0, 32'hBEEF_5566};
    vecs[7]  = '{1'b0, 32'h0000_00FE, 32'h0000_0000, 1'b1, 1'b0, 32'h1122_3344};
    vecs[8]  = '{1'b0, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h2233_44CC};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h3344_CCDD};
    vecs[10] = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h3344_CCDD};
    vecs[11] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b1, 32'h3344_CCDD};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h3344_CCDD};
    vecs[13] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h2233_44CC};
    vecs[14] = '{1'b1, 32'h8000_0000, 32'h0BAD_0BAD, 1'b0, 1'b1, 32'h2233_44CC};
    vecs[15] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h3344_CCDD};

    repeat (3) @(posedge clk);
    #1;
    check("rst1.data", rd_data1, 32'd0);
    check("rst1.valid", {31'd0, rd_valid1}, 32'd0);
    check("rst1.fault", {31'd0, addr_fault1}, 32'd0);
    check3("rst3", 1'b0, 1'b0, 32'd0);
    rst1_n = 1'b1;
    rst3_n = 1'b1;

    // Latency-1 table: each vector's response is visible right after its own edge.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].wr, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d.valid", i), {31'd0, rd_valid1}, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d.fault", i), {31'd0, addr_fault1}, {31'd0, vecs[i].ef});
      check($sformatf("vec%0d.data", i), rd_data1, vecs[i].ed);
    end

    // Latency-3 back-to-back reads; dut3 saw the same writes as dut1.
    step(1'b1, 32'h0000_0004, 32'h0102_0304);
    step(1'b1, 32'h0000_0008, 32'hA5A5_5A5A);
    step(1'b0, 32'h0000_0000, 32'h0000_0000);
    check3("l3.e1", 1'b0, 1'b0, 32'h3344_CCDD);
    step(1'b0, 32'h0000_0004, 32'h0000_0000);
    check3("l3.e2", 1'b0, 1'b0, 32'h3344_CCDD);
    step(1'b0, 32'h0000_0008, 32'h0000_0000);
    check3("l3.e3", 1'b1, 1'b0, 32'h3344_CCDD);
    step(1'b1, 32'h0000_0040, 32'h0000_0000);
    check3("l3.e4", 1'b1, 1'b0, 32'h0102_0304);
    step(1'b1, 32'h0000_0040, 32'h0000_0000);
    check3("l3.e5", 1'b1, 1'b0, 32'hA5A5_5A5A);
    step(1'b1, 32'h0000_0040, 32'h0000_0000);
    check3("l3.e6", 1'b0, 1'b0, 32'hA5A5_5A5A);

    // Mid-flight reset: the pending read must never surface, and RAM must survive.
    step(1'b0, 32'h0000_0004, 32'h0000_0000);
    rst3_n = 1'b0;
    #1;
    check3("mid.inrst", 1'b0, 1'b0, 32'd0);
    step(1'b1, 32'h0000_0004, 32'hFFFF_FFFF);
    rst3_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h0000_0040, 32'h0000_0000);
      check3($sformatf("mid.post%0d", k), 1'b0, 1'b0, 32'd0);
    end
    step(1'b0, 32'h0000_0004, 32'h0000_0000);
    step(1'b1, 32'h0000_0040, 32'h0000_0000);
    check3("mid.lat2", 1'b0, 1'b0, 32'd0);
    step(1'b1, 32'h0000_0040, 32'h0000_0000);
    check3("mid.keep", 1'b1, 1'b0, 32'h0102_0304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
